// File: rtl/sva_seq_driver.sv
// sva_seq_driver: replays queued "a, gap, b" scenarios for a ##[1:$] checker.
// A small command FIFO feeds a five-state waveform generator. The generator
// raises exp_succ on the same cycle as b, so a scoreboard can compare it
// against the checker's success outputs.
module sva_seq_driver #(
  parameter int unsigned LEN_WIDTH = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 gclk,
  input  logic                 grst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [LEN_WIDTH-1:0] cmd_idle_len,
  input  logic [LEN_WIDTH-1:0] cmd_gap_len,
  input  logic                 cmd_gap_a,
  output logic                 a,
  output logic                 b,
  output logic                 exp_succ,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] done_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef struct packed {
    logic [LEN_WIDTH-1:0] idle_len;
    logic [LEN_WIDTH-1:0] gap_len;
    logic                 gap_a;
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    TRIG = 3'd2,
    GAP  = 3'd3,
    FIRE = 3'd4
  } state_t;

  cmd_t                 mem [DEPTH];
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [PW-1:0]        wr_nxt, rd_nxt;
  logic                 empty, empty_nxt, full_nxt;
  logic                 push, pop;
  cmd_t                 head;

  state_t               state;
  logic [LEN_WIDTH-1:0] cnt;
  logic [LEN_WIDTH-1:0] gap_len_q;
  logic                 gap_a_q;
  logic                 idle_nxt;

  // FIFO status and handshake decode from the registered pointers
  always_comb begin
    empty     = (wr_ptr == rd_ptr);
    push      = cmd_valid && cmd_ready;
    pop       = (state == IDLE) && !empty;
    head      = mem[rd_ptr[AW-1:0]];
    wr_nxt    = wr_ptr + PW'(push);
    rd_nxt    = rd_ptr + PW'(pop);
    empty_nxt = (wr_nxt == rd_nxt);
    full_nxt  = (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
  end

  // Whether the generator will sit in IDLE after the coming edge
  always_comb begin
    idle_nxt = 1'b1;
    case (state)
      IDLE:           idle_nxt = !pop;
      PRE, TRIG, GAP: idle_nxt = 1'b0;
      default:        idle_nxt = 1'b1;
    endcase
  end

  // FIFO storage; contents need no reset because the pointers guard them
  always_ff @(posedge gclk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= '{idle_len: cmd_idle_len, gap_len: cmd_gap_len, gap_a: cmd_gap_a};
    end
  end

  // FIFO pointers plus registered cmd_ready and busy
  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
    end else begin
      wr_ptr    <= wr_nxt;
      rd_ptr    <= rd_nxt;
      cmd_ready <= !full_nxt;
      busy      <= !idle_nxt || !empty_nxt;
    end
  end

  // Scenario FSM; a/b/exp_succ are registered to match the state being entered
  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      state     <= IDLE;
      cnt       <= '0;
      gap_len_q <= '0;
      gap_a_q   <= 1'b0;
      a         <= 1'b0;
      b         <= 1'b0;
      exp_succ  <= 1'b0;
      done_cnt  <= '0;
    end else begin
      a        <= 1'b0;
      b        <= 1'b0;
      exp_succ <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            gap_len_q <= head.gap_len;
            gap_a_q   <= head.gap_a;
            if (head.idle_len == '0) begin
              state <= TRIG;
              a     <= 1'b1;
            end else begin
              cnt   <= head.idle_len;
              state <= PRE;
            end
          end
        end
        PRE: begin
          cnt <= cnt - LEN_WIDTH'(1);
          if (cnt == LEN_WIDTH'(1)) begin
            state <= TRIG;
            a     <= 1'b1;
          end
        end
        TRIG: begin
          if (gap_len_q == '0) begin
            state    <= FIRE;
            b        <= 1'b1;
            exp_succ <= 1'b1;
          end else begin
            cnt   <= gap_len_q;
            state <= GAP;
            a     <= gap_a_q;
          end
        end
        GAP: begin
          cnt <= cnt - LEN_WIDTH'(1);
          if (cnt == LEN_WIDTH'(1)) begin
            state    <= FIRE;
            b        <= 1'b1;
            exp_succ <= 1'b1;
          end else begin
            a <= gap_a_q;
          end
        end
        FIRE: begin
          done_cnt <= done_cnt + CNT_WIDTH'(1);
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sva_seq_driver.sv
// Directed bench for sva_seq_driver: waveform shapes, backpressure, reset abort, counter wrap.
module tb_sva_seq_driver;

  logic       gclk = 1'b0;
  logic       grst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_idle_len = 8'd0;
  logic [7:0] cmd_gap_len = 8'd0;
  logic       cmd_gap_a = 1'b0;

  logic        cmd_ready, a, b, exp_succ, busy;
  logic [15:0] done_cnt;
  logic        cmd_ready_w, a_w, b_w, exp_succ_w, busy_w;
  logic [1:0]  done_cnt_w;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 gclk = ~gclk;

  sva_seq_driver dut (
    .gclk(gclk), .grst(grst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_idle_len(cmd_idle_len), .cmd_gap_len(cmd_gap_len), .cmd_gap_a(cmd_gap_a),
    .a(a), .b(b), .exp_succ(exp_succ), .busy(busy), .done_cnt(done_cnt)
  );

  sva_seq_driver #(.CNT_WIDTH(2)) dut_w (
    .gclk(gclk), .grst(grst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_w),
    .cmd_idle_len(cmd_idle_len), .cmd_gap_len(cmd_gap_len), .cmd_gap_a(cmd_gap_a),
    .a(a_w), .b(b_w), .exp_succ(exp_succ_w), .busy(busy_w), .done_cnt(done_cnt_w)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic push(input int il, input int gl, input logic ga);
    check("push_ready", 32'(cmd_ready), 32'd1);
    cmd_valid    = 1'b1;
    cmd_idle_len = 8'(il);
    cmd_gap_len  = 8'(gl);
    cmd_gap_a    = ga;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Push one command and check {a,b,exp_succ} for each cycle after the pop edge:
  // idle cycles 000, trigger 100, gap cycles {gap_a,0,0}, fire 011.
  task automatic run_scen(input string tag, input int il, input int gl, input logic ga);
    logic [2:0] e;
    push(il, gl, ga);
    for (int c = 1; c <= il + gl + 2; c++) begin
      tick();
      if (c <= il)               e = 3'b000;
      else if (c == il + 1)      e = 3'b100;
      else if (c <= il + gl + 1) e = {ga, 2'b00};
      else                       e = 3'b011;
      check($sformatf("%s_c%0d", tag, c), 32'({a, b, exp_succ}), 32'(e));
      if (c == 1) check($sformatf("%s_busy", tag), 32'(busy), 32'd1);
    end
    tick();
  endtask

  initial begin
    int acc, pulses, last, gap_bad, bmis, stray;
    int wrap_exp [5];
    wrap_exp = '{1, 2, 3, 0, 1};

    // Reset values
    #2 grst = 1'b1;
    #2;
    check("rst_a", 32'(a), 32'd0);
    check("rst_b", 32'(b), 32'd0);
    check("rst_exp", 32'(exp_succ), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_done", 32'(done_cnt), 32'd0);
    repeat (3) @(posedge gclk);
    #1 grst = 1'b0;
    tick();

    // Single command {2,3,0}: a=0,0,1,0,0,0 then b on cycle 7
    run_scen("single", 2, 3, 1'b0);
    check("single_done", 32'(done_cnt), 32'd1);
    check("single_idle", 32'(busy), 32'd0);

    // Zero lengths: a on cycle 1, b on cycle 2
    run_scen("zero", 0, 0, 1'b0);
    check("zero_done", 32'(done_cnt), 32'd2);

    // Gap with a held: a=0,1,1,1 then b
    run_scen("gapa", 1, 2, 1'b1);
    check("gapa_done", 32'(done_cnt), 32'd3);
    check("gapa_idle", 32'(busy), 32'd0);

    // Backpressure: offer {5,5,0} for 6 cycles; first pops immediately, 4 more fill
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      cmd_valid = 1'b1; cmd_idle_len = 8'd5; cmd_gap_len = 8'd5; cmd_gap_a = 1'b0;
      if (cmd_ready) acc++;
      tick();
    end
    cmd_valid = 1'b0;
    check("bp_accepted", 32'(acc), 32'd5);
    check("bp_ready_low", 32'(cmd_ready), 32'd0);
    check("bp_busy", 32'(busy), 32'd1);
    pulses = 0; last = -1; gap_bad = 0; bmis = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (b !== exp_succ) bmis++;
      if (exp_succ) begin
        if (last >= 0 && (c - last) != 13) gap_bad++;
        last = c;
        pulses++;
      end
    end
    check("bp_pulses", 32'(pulses), 32'd5);
    check("bp_spacing", 32'(gap_bad), 32'd0);
    check("bp_b_eq_exp", 32'(bmis), 32'd0);
    check("bp_done", 32'(done_cnt), 32'd8);
    check("bp_ready_back", 32'(cmd_ready), 32'd1);
    check("bp_idle", 32'(busy), 32'd0);

    // Reset mid-scenario: {0,10,0} running in GAP with two more queued
    cmd_valid = 1'b1; cmd_idle_len = 8'd0; cmd_gap_len = 8'd10; cmd_gap_a = 1'b0;
    tick(); tick(); tick();
    cmd_valid = 1'b0;
    tick(); tick();
    check("mid_busy_pre", 32'(busy), 32'd1);
    check("mid_done_pre", 32'(done_cnt), 32'd8);
    #3 grst = 1'b1;
    #1;
    check("mid_a", 32'(a), 32'd0);
    check("mid_b", 32'(b), 32'd0);
    check("mid_exp", 32'(exp_succ), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_done", 32'(done_cnt), 32'd0);
    check("mid_ready", 32'(cmd_ready), 32'd1);
    repeat (2) @(posedge gclk);
    #1 grst = 1'b0;
    stray = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (a || b || exp_succ || busy) stray++;
    end
    check("mid_no_stray", 32'(stray), 32'd0);

    // Counter wrap on the 2-bit instance alongside the 16-bit one
    for (int i = 0; i < 5; i++) begin
      push(0, 0, 1'b0);
      tick(); tick(); tick();
      check($sformatf("wrap_w%0d", i), 32'(done_cnt_w), 32'(wrap_exp[i]));
      check($sformatf("wrap_d%0d", i), 32'(done_cnt), 32'(i + 1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
